// File: rtl/btn_pkg.sv
// btn_pkg: shared channel indices, default channel count and FSM encoding for the button front end
package btn_pkg;
  localparam int NBTN_DEFAULT = 9;
  localparam int BTN_H_INC   = 0;
  localparam int BTN_M_INC   = 1;
  localparam int BTN_S_INC   = 2;
  localparam int BTN_CONFIRM = 3;
  localparam int BTN_START   = 4;
  localparam int BTN_CLEAR   = 5;
  localparam int BTN_ADD5    = 6;
  localparam int BTN_ADD10   = 7;
  localparam int BTN_ADD15   = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button's synchroniser, debouncer and pulse FSM; BTN_AUTOREPEAT_EN adds hold-to-repeat
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS      = 20,
`ifdef BTN_AUTOREPEAT_EN
  parameter bit REPEAT_EN        = 1'b0,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100,
`endif
  parameter bit ACTIVE_LOW       = 1'b0
) (
  input  logic clk_1k,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_MS);
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic diff, flip, rise, fall, pulse_nxt;
  btn_state_t state, state_nxt;
  // level flips on the edge where the sample has disagreed for DEBOUNCE_MS+1 edges, giving press-to-level latency of 2+DEBOUNCE_MS
  assign diff = (sync[1] ^ ACTIVE_LOW) != level;
  assign flip = diff && deb_cnt == DEB_LAST;
  assign rise = flip && !level;
  assign fall = flip && level;
  always_ff @(posedge clk_1k or posedge rst)
    if (rst) begin
      sync    <= {2{ACTIVE_LOW}};
      deb_cnt <= '0;
      level   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      deb_cnt <= (!diff || flip) ? '0 : deb_cnt + 1'b1;
      level   <= level ^ flip;
    end
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY_MS, REPEAT_PERIOD_MS));
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_MS - 1);
  logic [RW-1:0] rpt_cnt, rpt_nxt;
  always_ff @(posedge clk_1k or posedge rst)
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_nxt;
      pulse   <= pulse_nxt;
    end
  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt_cnt + 1'b1;
    pulse_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        rpt_nxt   = '0;
        state_nxt = rise ? HELD : IDLE;
        pulse_nxt = rise;
      end
      HELD:
        if (fall) state_nxt = IDLE;
        else if (REPEAT_EN && rpt_cnt == DLY_LAST) begin
          state_nxt = REPEAT;
          pulse_nxt = 1'b1;
          rpt_nxt   = '0;
        end
      REPEAT:
        if (fall) state_nxt = IDLE;
        else if (rpt_cnt == PER_LAST) begin
          pulse_nxt = 1'b1;
          rpt_nxt   = '0;
        end
      default: state_nxt = IDLE;
    endcase
  end
`else
  always_ff @(posedge clk_1k or posedge rst)
    if (rst) begin
      state <= IDLE;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      pulse <= pulse_nxt;
    end
  always_comb begin
    state_nxt = rise ? HELD : fall ? IDLE : state;
    pulse_nxt = rise;
  end
`endif
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: panel button front end producing clk_1k press pulses and debounced levels; BTN_AUTOREPEAT_EN enables auto-repeat
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int              NBTN             = NBTN_DEFAULT,
  parameter int              DEBOUNCE_MS      = 20,
  parameter int              REPEAT_DELAY_MS  = 500,
  parameter int              REPEAT_PERIOD_MS = 100,
  parameter logic [NBTN-1:0] REPEAT_MASK      = NBTN'(3'b111),
  parameter bit              ACTIVE_LOW       = 1'b0
) (
  input  logic            clk_1k,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_pulse,
  output logic [NBTN-1:0] btn_level
);
  // these minimums keep any btn_pulse bit from being high two cycles in a row
  if (DEBOUNCE_MS < 2) begin : g_deb_chk
    $error("DEBOUNCE_MS must be at least 2");
  end
  if (REPEAT_PERIOD_MS < 2 || REPEAT_DELAY_MS < 2) begin : g_rpt_chk
    $error("REPEAT_DELAY_MS and REPEAT_PERIOD_MS must be at least 2");
  end
  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
`ifdef BTN_AUTOREPEAT_EN
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS),
`endif
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk_1k(clk_1k),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .pulse (btn_pulse[i]),
      .level (btn_level[i])
    );
  end
endmodule
